// File: rtl/adda_capture_sequencer.sv
// ADC capture / DAC playback sequencer.
// Waits for an armed level-crossing trigger on the ADC stream, fills a
// DEPTH-sample buffer, then replays it to the DAC once or continuously.
module adda_capture_sequencer #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [7:0]  IDLE_CODE  = 8'h80
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic [7:0] i_ad_sample,
    input  logic       i_arm,
    input  logic       i_abort,
    input  logic [7:0] i_trig_level,
    input  logic       i_trig_rising,
    input  logic       i_loop,
    output logic [7:0] o_da_value,
    output logic [1:0] o_state,
    output logic       o_busy,
    output logic       o_done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_PLAYBACK = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [DEPTH_LOG2-1:0]  wr_addr_q, wr_addr_d;
    logic [DEPTH_LOG2-1:0]  rd_addr_q, rd_addr_d;
    // rd_active: addresses are still being issued to the buffer
    logic                   rd_active_q, rd_active_d;
    // rd_valid: ram_q holds a sample that belongs on the DAC next cycle
    logic                   rd_valid_q, rd_valid_d;
    logic [7:0]             da_q, da_d;
    logic                   done_q, done_d;

    logic                   wr_en;
    logic [DEPTH_LOG2-1:0]  wr_addr;
    logic [7:0]             wr_data;
    logic                   rd_en;
    logic                   trig_fire;

    logic [7:0]             mem [DEPTH];
    logic [7:0]             ram_q;

    // Level-crossing detector between the held previous sample and the current one
    always_comb begin
        if (i_trig_rising) begin
            trig_fire = (prev_q < i_trig_level) && (i_ad_sample >= i_trig_level);
        end else begin
            trig_fire = (prev_q > i_trig_level) && (i_ad_sample <= i_trig_level);
        end
    end

    // Next-state, counter and buffer-port control; abort overrides everything
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        rd_active_d  = rd_active_q;
        rd_valid_d   = 1'b0;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = wr_addr_q;
        wr_data      = i_ad_sample;
        rd_en        = 1'b0;

        if (i_abort) begin
            state_d      = ST_IDLE;
            prev_valid_d = 1'b0;
            wr_addr_d    = '0;
            rd_addr_d    = '0;
            rd_active_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_arm) begin
                        state_d      = ST_ARMED;
                        prev_valid_d = 1'b0;
                    end
                end
                ST_ARMED: begin
                    // The first armed cycle only loads prev; stale prev never triggers
                    if (prev_valid_q && trig_fire) begin
                        wr_en     = 1'b1;
                        wr_addr   = '0;
                        wr_addr_d = ADDR_ONE;
                        state_d   = ST_CAPTURE;
                    end else begin
                        prev_d       = i_ad_sample;
                        prev_valid_d = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d     = ST_PLAYBACK;
                        rd_addr_d   = '0;
                        rd_active_d = 1'b1;
                    end
                end
                ST_PLAYBACK: begin
                    if (rd_active_q) begin
                        rd_en      = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rd_addr_q + 1'b1;
                        // Loop decision is taken only at the wrap point
                        if ((rd_addr_q == LAST_ADDR) && !i_loop) begin
                            rd_active_d = 1'b0;
                        end
                    end else if (!rd_valid_q) begin
                        // Pipeline drained: last sample has had its one cycle on the DAC
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // DAC output code: buffered sample when valid, midscale otherwise
    always_comb begin
        da_d = IDLE_CODE;
        if (rd_valid_q && !i_abort) begin
            da_d = ram_q;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_active_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            da_q         <= IDLE_CODE;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            rd_active_q  <= rd_active_d;
            rd_valid_q   <= rd_valid_d;
            da_q         <= da_d;
            done_q       <= done_d;
        end
    end

    // Sample buffer: one write port, one registered read port, contents never reset
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr_q];
        end
    end

    assign o_da_value = da_q;
    assign o_state    = state_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;

endmodule

// File: tb/tb_adda_capture_sequencer.sv
// Directed bench for adda_capture_sequencer with a 16-sample buffer.
module tb_adda_capture_sequencer;

    logic       i_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_ad_sample = 8'h00;
    logic       i_arm = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_trig_level = 8'h00;
    logic       i_trig_rising = 1'b1;
    logic       i_loop = 1'b0;
    logic [7:0] o_da_value;
    logic [1:0] o_state;
    logic       o_busy;
    logic       o_done;

    int compared = 0;
    int mismatched = 0;

    adda_capture_sequencer #(
        .DEPTH_LOG2 (4),
        .IDLE_CODE  (8'h80)
    ) dut (
        .i_clk         (i_clk),
        .reset         (reset),
        .i_ad_sample   (i_ad_sample),
        .i_arm         (i_arm),
        .i_abort       (i_abort),
        .i_trig_level  (i_trig_level),
        .i_trig_rising (i_trig_rising),
        .i_loop        (i_loop),
        .o_da_value    (o_da_value),
        .o_state       (o_state),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_state", {6'd0, o_state}, 8'd0);
        check("rst_busy", {7'd0, o_busy}, 8'd0);
        check("rst_done", {7'd0, o_done}, 8'd0);
        check("rst_da", o_da_value, 8'h80);
        reset = 1'b0;

        // Rising trigger on 0x50, then single playback of {0x50, 1..15}
        i_trig_level = 8'h40; i_trig_rising = 1'b1; i_loop = 1'b0; i_arm = 1'b1;
        tick();
        check("arm_state", {6'd0, o_state}, 8'd1);
        check("arm_busy", {7'd0, o_busy}, 8'd1);
        i_arm = 1'b0;
        i_ad_sample = 8'h10; tick(); check("rise_10", {6'd0, o_state}, 8'd1);
        i_ad_sample = 8'h30; tick(); check("rise_30", {6'd0, o_state}, 8'd1);
        i_ad_sample = 8'h50; tick(); check("rise_50", {6'd0, o_state}, 8'd2);
        for (int a = 1; a < 16; a++) begin
            i_ad_sample = 8'(a);
            tick();
        end
        check("cap1_to_play", {6'd0, o_state}, 8'd3);
        check("play1_p0", o_da_value, 8'h80);
        tick();
        check("play1_p1", o_da_value, 8'h80);
        i_arm = 1'b1;  // ignored during playback, re-arms once back in IDLE
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("play1_s%0d", k), o_da_value, (k == 0) ? 8'h50 : 8'(k));
            check($sformatf("play1_nodone%0d", k), {7'd0, o_done}, 8'd0);
        end
        tick();
        check("play1_end_da", o_da_value, 8'h80);
        check("play1_end_done", {7'd0, o_done}, 8'd1);
        check("play1_end_state", {6'd0, o_state}, 8'd0);
        check("play1_end_busy", {7'd0, o_busy}, 8'd0);
        tick();
        check("rearm_state", {6'd0, o_state}, 8'd1);
        check("rearm_done_clr", {7'd0, o_done}, 8'd0);
        i_arm = 1'b0;
        // Leave a high stale previous sample behind, then abort out of ARMED
        i_ad_sample = 8'h60; tick();
        i_abort = 1'b1; tick();
        check("abort_armed_state", {6'd0, o_state}, 8'd0);
        check("abort_armed_da", o_da_value, 8'h80);
        i_abort = 1'b0;

        // Falling trigger with first-cycle guard; abort at write address 7
        i_trig_level = 8'h40; i_trig_rising = 1'b0; i_arm = 1'b1;
        tick();
        check("fall_arm", {6'd0, o_state}, 8'd1);
        i_arm = 1'b0;
        i_ad_sample = 8'h20; tick(); check("fall_guard", {6'd0, o_state}, 8'd1);
        i_ad_sample = 8'h20; tick(); check("fall_20", {6'd0, o_state}, 8'd1);
        i_ad_sample = 8'h60; tick(); check("fall_60", {6'd0, o_state}, 8'd1);
        i_ad_sample = 8'h30; tick(); check("fall_30", {6'd0, o_state}, 8'd2);
        for (int a = 1; a < 7; a++) begin
            i_ad_sample = 8'(a);
            tick();
        end
        check("cap_before_abort", {6'd0, o_state}, 8'd2);
        i_abort = 1'b1; tick();
        check("abort_cap_state", {6'd0, o_state}, 8'd0);
        check("abort_cap_da", o_da_value, 8'h80);
        check("abort_cap_done", {7'd0, o_done}, 8'd0);
        i_abort = 1'b0; tick();
        check("abort_cap_done2", {7'd0, o_done}, 8'd0);
        check("abort_cap_idle", {6'd0, o_state}, 8'd0);

        // Re-arm, capture ramp 0..15, loop playback then stop after the pass
        i_trig_level = 8'h00; i_trig_rising = 1'b0; i_loop = 1'b1; i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        i_ad_sample = 8'h05; tick();
        i_ad_sample = 8'h05; tick();
        i_ad_sample = 8'h00; tick();
        check("loop_trig", {6'd0, o_state}, 8'd2);
        for (int a = 1; a < 16; a++) begin
            i_ad_sample = 8'(a);
            tick();
        end
        check("loop_play", {6'd0, o_state}, 8'd3);
        tick();
        for (int n = 0; n < 64; n++) begin
            tick();
            check($sformatf("loop_s%0d", n), o_da_value, 8'(n % 16));
            check($sformatf("loop_nodone%0d", n), {7'd0, o_done}, 8'd0);
            if (n == 49) i_loop = 1'b0;
        end
        tick();
        check("loop_end_da", o_da_value, 8'h80);
        check("loop_end_done", {7'd0, o_done}, 8'd1);
        check("loop_end_state", {6'd0, o_state}, 8'd0);
        tick();
        check("loop_done_once", {7'd0, o_done}, 8'd0);

        // Reset together with abort during playback
        i_trig_level = 8'h40; i_trig_rising = 1'b1; i_loop = 1'b1; i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        i_ad_sample = 8'h10; tick();
        i_ad_sample = 8'h50; tick();
        check("rp_trig", {6'd0, o_state}, 8'd2);
        for (int a = 1; a < 16; a++) begin
            i_ad_sample = 8'(a);
            tick();
        end
        check("rp_play", {6'd0, o_state}, 8'd3);
        tick();
        tick(); check("rp_s0", o_da_value, 8'h50);
        tick(); check("rp_s1", o_da_value, 8'h01);
        reset = 1'b1; i_abort = 1'b1; tick();
        check("rp_state", {6'd0, o_state}, 8'd0);
        check("rp_da", o_da_value, 8'h80);
        check("rp_done", {7'd0, o_done}, 8'd0);
        check("rp_busy", {7'd0, o_busy}, 8'd0);
        reset = 1'b0; i_abort = 1'b0; tick();
        check("rp_after_state", {6'd0, o_state}, 8'd0);
        check("rp_after_da", o_da_value, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
